// File: rtl/crc_frame_ctrl.sv
// Store-and-forward sequencer around a serial 8-bit CRC engine: buffers a byte
// frame, feeds it LSB-first to the engine, gathers the serial CRC, re-seeds.
module crc_frame_ctrl #(
  parameter  int MAX_LEN = 16,
  parameter  int TIMEOUT = 12,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic          eng_data,
  output logic          eng_active,
  output logic          eng_rst_n,
  input  logic          eng_crc,
  input  logic          eng_valid,
  output logic [7:0]    crc_out,
  output logic [LW-1:0] crc_len,
  output logic          crc_valid,
  input  logic          crc_ready,
  output logic          err,
  output logic          busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int IW = LW + 3;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_COLLECT, S_LOAD, S_FEED, S_DRAIN, S_OUT, S_ARM
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] len_q,   len_d;
  logic          ovf_q,   ovf_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [2:0]    n_q,     n_d;
  logic [TW-1:0] tcnt_q,  tcnt_d;
  logic [7:0]    crc_q,   crc_d;
  logic          eng_active_q, eng_active_d;
  logic          eng_data_q,   eng_data_d;
  logic          eng_rst_n_q,  eng_rst_n_d;
  logic          err_q,        err_d;

  logic [7:0]    mem_q [MAX_LEN];
  logic          accept;
  logic          full;
  logic          rd_bit;

  assign accept = in_valid & in_ready;
  assign full   = (count_q == LW'(MAX_LEN));
  // idx_q addresses the bit presented on the following cycle
  assign rd_bit = mem_q[AW'(idx_q[IW-1:3])][idx_q[2:0]];

  always_ff @(posedge CLK) begin
    if (accept && !full) mem_q[AW'(count_q)] <= in_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_COLLECT;
      count_q      <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      idx_q        <= '0;
      n_q          <= '0;
      tcnt_q       <= '0;
      crc_q        <= '0;
      eng_active_q <= 1'b0;
      eng_data_q   <= 1'b0;
      eng_rst_n_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      tcnt_q       <= tcnt_d;
      crc_q        <= crc_d;
      eng_active_q <= eng_active_d;
      eng_data_q   <= eng_data_d;
      eng_rst_n_q  <= eng_rst_n_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    idx_d        = idx_q;
    n_d          = n_q;
    tcnt_d       = tcnt_q;
    crc_d        = crc_q;
    eng_active_d = eng_active_q;
    eng_data_d   = eng_data_q;
    err_d        = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (full) ovf_d = 1'b1;
          else      count_d = count_q + 1'b1;
          if (in_last) begin
            // An overflowed frame never reaches the engine
            if (full || ovf_q) begin
              err_d   = 1'b1;
              count_d = '0;
              ovf_d   = 1'b0;
            end else begin
              len_d   = count_q + 1'b1;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        eng_active_d = 1'b1;
        eng_data_d   = mem_q[0][0];
        idx_d        = IW'(1);
        n_d          = '0;
        tcnt_d       = '0;
        crc_d        = '0;
        state_d      = S_FEED;
      end
      S_FEED: begin
        if (idx_q == {len_q, 3'b000}) begin
          eng_active_d = 1'b0;
          eng_data_d   = 1'b0;
          state_d      = S_DRAIN;
        end else begin
          eng_data_d = rd_bit;
          idx_d      = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        tcnt_d = tcnt_q + 1'b1;
        if (eng_valid) begin
          crc_d[n_q] = eng_crc;
          n_d        = n_q + 1'b1;
        end
        if (eng_valid && n_q == 3'd7) begin
          state_d = S_OUT;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_ARM;
        end
      end
      S_OUT: begin
        if (crc_ready) state_d = S_ARM;
      end
      S_ARM: begin
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
    eng_rst_n_d = (state_d != S_ARM);
  end

  always_comb begin
    in_ready  = (state_q == S_COLLECT);
    busy      = (state_q != S_COLLECT);
    crc_valid = (state_q == S_OUT);
  end

  assign eng_active = eng_active_q;
  assign eng_data   = eng_data_q;
  assign eng_rst_n  = eng_rst_n_q;
  assign crc_out    = crc_q;
  assign crc_len    = len_q;
  assign err        = err_q;

endmodule

// File: doc/crc_frame_ctrl.md
# crc_frame_ctrl

Store-and-forward sequencer for the team's serial 8-bit CRC engine. Accepts a byte frame over a valid/ready stream and buffers it whole, because the engine starts unloading its CRC as soon as its shift-enable drops. It then streams the frame bit-serially into the engine, collects the 8 serial CRC bits into a byte, presents that byte on an output handshake, and re-seeds the engine before the next frame.

## Interface
- MAX_LEN, 16, maximum frame length in bytes (2..256)
- TIMEOUT, 12, cycles allowed for the engine to return 8 CRC bits after feed ends
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- in_data  in  8  frame byte
- in_valid  in  1  in_data valid
- in_last  in  1  byte is last of frame
- in_ready  out  1  byte accepted when in_valid & in_ready
- eng_data  out  1  serial bit to engine, registered
- eng_active  out  1  engine shift-enable, registered
- eng_rst_n  out  1  engine reset (active-low), registered, glitch-free
- eng_crc  in  1  serial CRC bit from engine
- eng_valid  in  1  eng_crc valid
- crc_out  out  8  frame CRC, bit k = k-th serial bit received
- crc_len  out  clog2(MAX_LEN+1)  byte count of the frame
- crc_valid  out  1  crc_out/crc_len valid; held until crc_ready
- crc_ready  in  1  downstream accepts
- err  out  1  one-cycle pulse: overflow or timeout
- busy  out  1  high in every state except COLLECT

## Operation
- States: COLLECT, LOAD, FEED, DRAIN, OUT, ARM.
- COLLECT: in_ready=1. Each accepted byte is written to buf[count] and count increments.
  - On accepting a byte with in_last=1, go to LOAD with L = count+1.
  - Overflow: a byte accepted when count==MAX_LEN is discarded and the frame is flagged. On its in_last, pulse err, set count=0, stay in COLLECT; the engine is not touched.
- LOAD: one cycle; eng_active=1 and eng_data=buf[0][0] become registered for the next cycle. Go to FEED.
- FEED: eng_active=1 for exactly 8·L consecutive cycles. Data order is byte 0 first, LSB first within each byte. Never stalls.
- DRAIN: eng_active=0. Each cycle with eng_valid=1 shifts eng_crc into crc_out bit position n, then n increments.
  - After n=8, go to OUT.
  - If TIMEOUT cycles elapse in DRAIN with n<8, pulse err and go to ARM; no crc_valid.
- OUT: crc_valid=1, crc_len=L. On crc_valid & crc_ready, go to ARM.
- ARM: eng_rst_n=0 for exactly one cycle, which restores the engine seed and its output counter. Then count=0 and go to COLLECT.
- in_ready=0 in all states except COLLECT. eng_valid outside DRAIN is ignored.

## Timing
- Reset values: state COLLECT, count 0, in_ready 1, eng_active 0, eng_data 0, eng_rst_n 0, crc_out 0x00, crc_len 0, crc_valid 0, err 0, busy 0.
- eng_rst_n rises on the first CLK edge after RST deasserts.
- Last-byte handshake at cycle T:
  - LOAD is cycle T+1.
  - eng_active is high in cycles T+2 .. T+1+8L.
  - eng_active is low from T+2+8L.
- The engine returns eng_valid one cycle after eng_active falls, for 8 cycles. Nominal crc_valid is at cycle T+11+8L.
- crc_out and crc_len stay stable while crc_valid=1 and crc_ready=0.
- Frame-to-frame: after the OUT handshake, one ARM cycle follows; in_ready returns the cycle after that.
- RST asserted mid-frame: all state is cleared immediately, buffered bytes are lost, and outputs take their reset values. eng_rst_n=0 holds the engine in reset.
- Simultaneous in_valid & in_last with overflow: err is the only response; crc_valid is never asserted for that frame.

## Test plan
- Single byte 0x00 with in_last, crc_ready=1:
  - eng_active high exactly 8 cycles, eng_data all 0.
  - crc_out=0x14, crc_len=1, crc_valid at T+19.
  - One-cycle eng_rst_n low follows.
- Two identical frames {0x00} back-to-back: both report crc_out=0x14, proving ARM re-seeds the engine. in_ready low from T+1 until the cycle after ARM.
- Frame {0xA5,0x3C,0xFF}:
  - eng_data sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1×8, with no gaps over 24 cycles.
  - crc_out matches the bit-accurate engine model; crc_len=3.
- MAX_LEN+1 bytes, last byte flagged: err pulses once on the last handshake, crc_valid stays 0, eng_active stays 0, and the next frame {0x00} gives 0x14.
- Hold crc_ready=0 for 5 cycles in OUT: crc_out and crc_len are stable and no ARM occurs until the handshake. Separately, force eng_valid=0 in DRAIN: err pulses after 12 cycles, followed by ARM.
- Assert RST during FEED of a 4-byte frame: all outputs return to reset values asynchronously, and the next frame {0x00} gives 0x14.
